br_resolve_unit: RTL and testbench
==================================

// Module: br_resolve_unit
// PURPOSE
// Consumes per-cycle branch-resolution info (brinfo) from the ALU/jump units and builds the core-wide brupdate.
// - b1: same-cycle resolve/mispredict masks; these feed back to every exe unit's kill and br_mask logic.
// - b2: registered, single oldest mispredict sent to the frontend/ROB for redirect.
// - Holds redirect state until the frontend acks, so younger mispredicts cannot issue a second redirect.
// PARAMETERS
// NUM_BR     2   brinfo ports (one per branch-capable ALU)
// MAX_BR     20  branch-mask width
// ROB_W      7   rob_idx width
// Fixed field widths: br_tag 5, ftq_idx 6, pc_lob 6, ldq/stq idx 5, cfi_type 3, pc_sel 2, target_offset 21.
// PORTS  (per-port vectors are packed, port i in slice i)
// clock                 in   1               clock
// reset                 in   1               synchronous, active-high
// brinfo_valid          in   NUM_BR          port resolves a branch/jalr
// brinfo_mispredict     in   NUM_BR          port mispredicted
// brinfo_taken          in   NUM_BR          resolved direction
// brinfo_br_mask        in   NUM_BR*MAX_BR   branches this uop depends on
// brinfo_br_tag         in   NUM_BR*5        own tag
// brinfo_rob_idx        in   NUM_BR*ROB_W    ROB position
// brinfo_ftq_idx/pc_lob/ldq_idx/stq_idx/cfi_type/pc_sel/target_offset   in   per-port   passthrough payload
// rob_head_idx          in   ROB_W           oldest ROB entry; used for age compare
// redirect_ack          in   1               frontend finished redirect
// flush                 in   1               ROB exception flush
// b1_resolve_mask       out  MAX_BR          comb
// b1_mispredict_mask    out  MAX_BR          comb
// b2_valid              out  1               registered
// b2_mispredict         out  1               registered
// b2_br_tag/rob_idx/ftq_idx/pc_lob/ldq_idx/stq_idx/cfi_type/pc_sel/target_offset/taken   out   registered payload of selected port
// redirect_pending      out  1               FSM in PENDING
// BEHAVIOUR
// - b1 (comb, unfiltered):
//   b1_resolve_mask = OR over valid ports of onehot(br_tag).
//   b1_mispredict_mask = OR over (valid & mispredict) ports of onehot(br_tag).
// - Age = (rob_idx - rob_head_idx) mod 2^ROB_W; smaller is older. Ties between ports: lower port index wins.
// - A candidate is a port with valid & mispredict whose br_mask does not intersect b1_mispredict_mask. Younger branches are dropped here.
// - sel = oldest candidate; accept = sel exists AND (state==IDLE OR age(sel) < age(pending_rob_idx)).
// - b2 (1-cycle latency, next edge):
//   b2_valid = |brinfo_valid & ~flush.
//   b2_mispredict = accept & ~flush.
//   Payload = sel's fields when accept, else the oldest valid port's fields, else hold.
// - FSM, 2 states:
//   IDLE -> PENDING on accept & ~flush; latch pending_rob_idx.
//   PENDING + accept (older) -> PENDING; reissue b2_mispredict; update pending_rob_idx.
//   PENDING + redirect_ack & ~accept -> IDLE.
//   Same cycle ack & accept -> PENDING; the new redirect wins.
//   Candidates not older than the pending branch never assert b2_mispredict.
//   flush (any state) -> IDLE next cycle; b2_valid and b2_mispredict = 0 next cycle. flush beats accept and ack.
// - redirect_pending = (state==PENDING).
// - Reset: state IDLE. b2_valid, b2_mispredict, redirect_pending, all b2 payload and pending_rob_idx = 0.
//   Reset mid-PENDING drops the redirect. b1 outputs stay comb during reset.
// - redirect_ack in IDLE is ignored.
// TESTING
// 1. head=0, port0 valid, mispredict, tag=3, rob=10 -> same cycle b1_mis=0x8 and b1_res=0x8; next cycle b2_mispredict=1, b2_rob_idx=10, redirect_pending=1.
// 2. head=120. port0 mispredict rob=3 tag=1. port1 mispredict rob=125 tag=2, br_mask=0 -> b2 chooses port1 (rob 125); b1_mis=0x6.
// 3. PENDING on rob=40 (head=0). Then mispredict rob=50 -> b2_valid=1, b2_mispredict=0. Then mispredict rob=20 -> b2_mispredict=1, b2_rob_idx=20.
// 4. port1 br_mask=0x1 and port0 tag=0 mispredicts, port1 older by rob -> port1 still rejected; b2_rob_idx = port0's rob.
// 5. PENDING, redirect_ack in the same cycle as an older mispredict -> stays PENDING; b2_mispredict=1. Ack alone later -> IDLE.
// 6. flush asserted with a mispredict, and reset asserted while PENDING -> next cycle b2_valid=0, b2_mispredict=0, redirect_pending=0.

Source files
------------

// File: rtl/br_resolve_unit.sv
// Branch resolution unit.
// Collects per-port branch resolution info and produces:
//   b1 : same-cycle resolve / mispredict tag masks (combinational)
//   b2 : registered oldest surviving mispredict with its payload
//   redirect_pending : a redirect is outstanding until the frontend acks it
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   brinfo_*                  - per-port resolution info, port i in slice i
//   rob_head_idx              - oldest ROB entry, reference point for age
//   redirect_ack, flush       - frontend redirect done, ROB exception flush
//   b1_resolve_mask / b1_mispredict_mask - combinational tag masks
//   b2_*                      - registered selected branch
//   redirect_pending          - redirect outstanding
module br_resolve_unit #(
   parameter int unsigned NUM_BR = 2,
   parameter int unsigned MAX_BR = 20,
   parameter int unsigned ROB_W  = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_BR-1:0]         brinfo_valid,
   input  logic [NUM_BR-1:0]         brinfo_mispredict,
   input  logic [NUM_BR-1:0]         brinfo_taken,
   input  logic [NUM_BR*MAX_BR-1:0]  brinfo_br_mask,
   input  logic [NUM_BR*5-1:0]       brinfo_br_tag,
   input  logic [NUM_BR*ROB_W-1:0]   brinfo_rob_idx,
   input  logic [NUM_BR*6-1:0]       brinfo_ftq_idx,
   input  logic [NUM_BR*6-1:0]       brinfo_pc_lob,
   input  logic [NUM_BR*5-1:0]       brinfo_ldq_idx,
   input  logic [NUM_BR*5-1:0]       brinfo_stq_idx,
   input  logic [NUM_BR*3-1:0]       brinfo_cfi_type,
   input  logic [NUM_BR*2-1:0]       brinfo_pc_sel,
   input  logic [NUM_BR*21-1:0]      brinfo_target_offset,
   input  logic [ROB_W-1:0]          rob_head_idx,
   input  logic                      redirect_ack,
   input  logic                      flush,
   output logic [MAX_BR-1:0]         b1_resolve_mask,
   output logic [MAX_BR-1:0]         b1_mispredict_mask,
   output logic                      b2_valid,
   output logic                      b2_mispredict,
   output logic [4:0]                b2_br_tag,
   output logic [ROB_W-1:0]          b2_rob_idx,
   output logic [5:0]                b2_ftq_idx,
   output logic [5:0]                b2_pc_lob,
   output logic [4:0]                b2_ldq_idx,
   output logic [4:0]                b2_stq_idx,
   output logic [2:0]                b2_cfi_type,
   output logic [1:0]                b2_pc_sel,
   output logic [20:0]               b2_target_offset,
   output logic                      b2_taken,
   output logic                      redirect_pending
);

   localparam int unsigned TAG_W   = 5;
   localparam int unsigned FTQ_W   = 6;
   localparam int unsigned LOB_W   = 6;
   localparam int unsigned LSQ_W   = 5;
   localparam int unsigned CFI_W   = 3;
   localparam int unsigned PCSEL_W = 2;
   localparam int unsigned TOFF_W  = 21;

   typedef struct packed {
      logic               taken;
      logic [TAG_W-1:0]   br_tag;
      logic [ROB_W-1:0]   rob_idx;
      logic [FTQ_W-1:0]   ftq_idx;
      logic [LOB_W-1:0]   pc_lob;
      logic [LSQ_W-1:0]   ldq_idx;
      logic [LSQ_W-1:0]   stq_idx;
      logic [CFI_W-1:0]   cfi_type;
      logic [PCSEL_W-1:0] pc_sel;
      logic [TOFF_W-1:0]  target_offset;
   } payload_t;

   typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ROB_W-1:0]  pending_rob_idx_q, pending_rob_idx_d;
   payload_t          b2_pl_q, b2_pl_d;
   logic              b2_valid_q, b2_valid_d;
   logic              b2_mispredict_q, b2_mispredict_d;

   payload_t          port_pl   [NUM_BR];
   logic [ROB_W-1:0]  port_age  [NUM_BR];
   logic [NUM_BR-1:0] port_cand;
   payload_t          sel_pl, old_pl;
   logic [ROB_W-1:0]  sel_age, old_age, pending_age;
   logic              sel_found, old_found, accept;

   // Unpack per-port fields and compute age relative to the ROB head
   always_comb begin
      for (int unsigned i = 0; i < NUM_BR; i++) begin
         port_pl[i].taken         = brinfo_taken[i];
         port_pl[i].br_tag        = brinfo_br_tag[i*TAG_W +: TAG_W];
         port_pl[i].rob_idx       = brinfo_rob_idx[i*ROB_W +: ROB_W];
         port_pl[i].ftq_idx       = brinfo_ftq_idx[i*FTQ_W +: FTQ_W];
         port_pl[i].pc_lob        = brinfo_pc_lob[i*LOB_W +: LOB_W];
         port_pl[i].ldq_idx       = brinfo_ldq_idx[i*LSQ_W +: LSQ_W];
         port_pl[i].stq_idx       = brinfo_stq_idx[i*LSQ_W +: LSQ_W];
         port_pl[i].cfi_type      = brinfo_cfi_type[i*CFI_W +: CFI_W];
         port_pl[i].pc_sel        = brinfo_pc_sel[i*PCSEL_W +: PCSEL_W];
         port_pl[i].target_offset = brinfo_target_offset[i*TOFF_W +: TOFF_W];
         port_age[i] = ROB_W'(brinfo_rob_idx[i*ROB_W +: ROB_W] - rob_head_idx);
      end
   end

   // b1 tag masks, unfiltered by dependency
   always_comb begin
      b1_resolve_mask    = '0;
      b1_mispredict_mask = '0;
      for (int unsigned i = 0; i < NUM_BR; i++) begin
         if (brinfo_valid[i])
            b1_resolve_mask = b1_resolve_mask | (MAX_BR'(1) << port_pl[i].br_tag);
         if (brinfo_valid[i] && brinfo_mispredict[i])
            b1_mispredict_mask = b1_mispredict_mask | (MAX_BR'(1) << port_pl[i].br_tag);
      end
   end

   // Drop mispredicts that depend on another branch mispredicting this cycle
   always_comb begin
      for (int unsigned i = 0; i < NUM_BR; i++) begin
         port_cand[i] = brinfo_valid[i] && brinfo_mispredict[i] &&
                        ((brinfo_br_mask[i*MAX_BR +: MAX_BR] & b1_mispredict_mask) == '0);
      end
   end

   // Oldest candidate and oldest valid port; strict compare keeps lower index on ties
   always_comb begin
      sel_found = 1'b0;
      sel_age   = '0;
      sel_pl    = '0;
      old_found = 1'b0;
      old_age   = '0;
      old_pl    = '0;
      for (int unsigned i = 0; i < NUM_BR; i++) begin
         if (port_cand[i] && (!sel_found || port_age[i] < sel_age)) begin
            sel_found = 1'b1;
            sel_age   = port_age[i];
            sel_pl    = port_pl[i];
         end
         if (brinfo_valid[i] && (!old_found || port_age[i] < old_age)) begin
            old_found = 1'b1;
            old_age   = port_age[i];
            old_pl    = port_pl[i];
         end
      end
   end

   assign pending_age = ROB_W'(pending_rob_idx_q - rob_head_idx);
   assign accept      = sel_found && (state_q == ST_IDLE || sel_age < pending_age);

   // Next-state and b2 next values; flush overrides accept and ack
   always_comb begin
      state_d           = state_q;
      pending_rob_idx_d = pending_rob_idx_q;
      b2_pl_d           = b2_pl_q;
      b2_valid_d        = (|brinfo_valid) && !flush;
      b2_mispredict_d   = accept && !flush;
      if (accept)
         b2_pl_d = sel_pl;
      else if (old_found)
         b2_pl_d = old_pl;
      if (flush) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         state_d           = ST_PENDING;
         pending_rob_idx_d = sel_pl.rob_idx;
      end else if (state_q == ST_PENDING && redirect_ack) begin
         state_d = ST_IDLE;
      end
   end

   // State and b2 registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         pending_rob_idx_q <= '0;
         b2_pl_q           <= '0;
         b2_valid_q        <= 1'b0;
         b2_mispredict_q   <= 1'b0;
      end else begin
         state_q           <= state_d;
         pending_rob_idx_q <= pending_rob_idx_d;
         b2_pl_q           <= b2_pl_d;
         b2_valid_q        <= b2_valid_d;
         b2_mispredict_q   <= b2_mispredict_d;
      end
   end

   assign b2_valid         = b2_valid_q;
   assign b2_mispredict    = b2_mispredict_q;
   assign b2_br_tag        = b2_pl_q.br_tag;
   assign b2_rob_idx       = b2_pl_q.rob_idx;
   assign b2_ftq_idx       = b2_pl_q.ftq_idx;
   assign b2_pc_lob        = b2_pl_q.pc_lob;
   assign b2_ldq_idx       = b2_pl_q.ldq_idx;
   assign b2_stq_idx       = b2_pl_q.stq_idx;
   assign b2_cfi_type      = b2_pl_q.cfi_type;
   assign b2_pc_sel        = b2_pl_q.pc_sel;
   assign b2_target_offset = b2_pl_q.target_offset;
   assign b2_taken         = b2_pl_q.taken;
   assign redirect_pending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  brinfo_valid, brinfo_mispredict, brinfo_taken;
   logic [39:0] brinfo_br_mask;
   logic [9:0]  brinfo_br_tag;
   logic [13:0] brinfo_rob_idx;
   logic [11:0] brinfo_ftq_idx, brinfo_pc_lob;
   logic [9:0]  brinfo_ldq_idx, brinfo_stq_idx;
   logic [5:0]  brinfo_cfi_type;
   logic [3:0]  brinfo_pc_sel;
   logic [41:0] brinfo_target_offset;
   logic [6:0]  rob_head_idx;
   logic        redirect_ack, flush;
   logic [19:0] b1_resolve_mask, b1_mispredict_mask;
   logic        b2_valid, b2_mispredict, b2_taken, redirect_pending;
   logic [4:0]  b2_br_tag, b2_ldq_idx, b2_stq_idx;
   logic [6:0]  b2_rob_idx;
   logic [5:0]  b2_ftq_idx, b2_pc_lob;
   logic [2:0]  b2_cfi_type;
   logic [1:0]  b2_pc_sel;
   logic [20:0] b2_target_offset;

   int nvec = 0;
   int nerr = 0;

   br_resolve_unit #(.NUM_BR(2), .MAX_BR(20), .ROB_W(7)) dut (
      .clock(clock), .reset(reset),
      .brinfo_valid(brinfo_valid), .brinfo_mispredict(brinfo_mispredict),
      .brinfo_taken(brinfo_taken), .brinfo_br_mask(brinfo_br_mask),
      .brinfo_br_tag(brinfo_br_tag), .brinfo_rob_idx(brinfo_rob_idx),
      .brinfo_ftq_idx(brinfo_ftq_idx), .brinfo_pc_lob(brinfo_pc_lob),
      .brinfo_ldq_idx(brinfo_ldq_idx), .brinfo_stq_idx(brinfo_stq_idx),
      .brinfo_cfi_type(brinfo_cfi_type), .brinfo_pc_sel(brinfo_pc_sel),
      .brinfo_target_offset(brinfo_target_offset),
      .rob_head_idx(rob_head_idx), .redirect_ack(redirect_ack), .flush(flush),
      .b1_resolve_mask(b1_resolve_mask), .b1_mispredict_mask(b1_mispredict_mask),
      .b2_valid(b2_valid), .b2_mispredict(b2_mispredict),
      .b2_br_tag(b2_br_tag), .b2_rob_idx(b2_rob_idx), .b2_ftq_idx(b2_ftq_idx),
      .b2_pc_lob(b2_pc_lob), .b2_ldq_idx(b2_ldq_idx), .b2_stq_idx(b2_stq_idx),
      .b2_cfi_type(b2_cfi_type), .b2_pc_sel(b2_pc_sel),
      .b2_target_offset(b2_target_offset), .b2_taken(b2_taken),
      .redirect_pending(redirect_pending)
   );

   always #5 clock = ~clock;

   // Advance one cycle and sample just after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      brinfo_valid = '0; brinfo_mispredict = '0; brinfo_taken = '0;
      brinfo_br_mask = '0; brinfo_br_tag = '0; brinfo_rob_idx = '0;
      brinfo_ftq_idx = '0; brinfo_pc_lob = '0; brinfo_ldq_idx = '0;
      brinfo_stq_idx = '0; brinfo_cfi_type = '0; brinfo_pc_sel = '0;
      brinfo_target_offset = '0; rob_head_idx = '0;
      redirect_ack = 1'b0; flush = 1'b0;
   endtask

   task automatic set_port(input int p, input bit v, input bit m, input bit tk,
                           input logic [19:0] msk, input int tag, input int rob);
      brinfo_valid[p] = v;
      brinfo_mispredict[p] = m;
      brinfo_taken[p] = tk;
      brinfo_br_mask[p*20 +: 20] = msk;
      brinfo_br_tag[p*5 +: 5] = 5'(tag);
      brinfo_rob_idx[p*7 +: 7] = 7'(rob);
   endtask

   task automatic set_payload(input int p, input int ftq, input int lob, input int ldq,
                              input int stq, input int cfi, input int psel, input int toff);
      brinfo_ftq_idx[p*6 +: 6] = 6'(ftq);
      brinfo_pc_lob[p*6 +: 6] = 6'(lob);
      brinfo_ldq_idx[p*5 +: 5] = 5'(ldq);
      brinfo_stq_idx[p*5 +: 5] = 5'(stq);
      brinfo_cfi_type[p*3 +: 3] = 3'(cfi);
      brinfo_pc_sel[p*2 +: 2] = 2'(psel);
      brinfo_target_offset[p*21 +: 21] = 21'(toff);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      set_port(0, 1, 1, 0, '0, 3, 10);
      tick();
      tick();
      nvec++; if (b2_valid !== 1'b0) begin nerr++; $display("FAIL reset_b2_valid got %0d exp 0", b2_valid); end
      nvec++; if (b2_mispredict !== 1'b0) begin nerr++; $display("FAIL reset_b2_mis got %0d exp 0", b2_mispredict); end
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL reset_pending got %0d exp 0", redirect_pending); end
      nvec++; if (b2_rob_idx !== 7'd0) begin nerr++; $display("FAIL reset_b2_rob got %0d exp 0", b2_rob_idx); end
      nvec++; if (b1_resolve_mask !== 20'h8) begin nerr++; $display("FAIL reset_b1_res_comb got %h exp 8", b1_resolve_mask); end
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single();
      do_reset();
      set_port(0, 1, 1, 1, '0, 3, 10);
      #1;
      nvec++; if (b1_mispredict_mask !== 20'h8) begin nerr++; $display("FAIL single_b1_mis got %h exp 8", b1_mispredict_mask); end
      nvec++; if (b1_resolve_mask !== 20'h8) begin nerr++; $display("FAIL single_b1_res got %h exp 8", b1_resolve_mask); end
      tick();
      clear_inputs();
      nvec++; if (b2_mispredict !== 1'b1) begin nerr++; $display("FAIL single_b2_mis got %0d exp 1", b2_mispredict); end
      nvec++; if (b2_rob_idx !== 7'd10) begin nerr++; $display("FAIL single_b2_rob got %0d exp 10", b2_rob_idx); end
      nvec++; if (redirect_pending !== 1'b1) begin nerr++; $display("FAIL single_pending got %0d exp 1", redirect_pending); end
      nvec++; if (b2_taken !== 1'b1) begin nerr++; $display("FAIL single_taken got %0d exp 1", b2_taken); end
   endtask

   task automatic test_age_wrap();
      do_reset();
      rob_head_idx = 7'd120;
      set_port(0, 1, 1, 0, '0, 1, 3);
      set_port(1, 1, 1, 0, '0, 2, 125);
      #1;
      nvec++; if (b1_mispredict_mask !== 20'h6) begin nerr++; $display("FAIL wrap_b1_mis got %h exp 6", b1_mispredict_mask); end
      tick();
      clear_inputs();
      nvec++; if (b2_rob_idx !== 7'd125) begin nerr++; $display("FAIL wrap_b2_rob got %0d exp 125", b2_rob_idx); end
      nvec++; if (b2_br_tag !== 5'd2) begin nerr++; $display("FAIL wrap_b2_tag got %0d exp 2", b2_br_tag); end
   endtask

   task automatic test_pending_older();
      do_reset();
      set_port(0, 1, 1, 0, '0, 1, 40);
      tick();
      nvec++; if (redirect_pending !== 1'b1) begin nerr++; $display("FAIL pend_first got %0d exp 1", redirect_pending); end
      set_port(0, 1, 1, 0, '0, 2, 50);
      tick();
      nvec++; if (b2_valid !== 1'b1) begin nerr++; $display("FAIL pend_younger_valid got %0d exp 1", b2_valid); end
      nvec++; if (b2_mispredict !== 1'b0) begin nerr++; $display("FAIL pend_younger_mis got %0d exp 0", b2_mispredict); end
      set_port(0, 1, 1, 0, '0, 3, 20);
      tick();
      clear_inputs();
      nvec++; if (b2_mispredict !== 1'b1) begin nerr++; $display("FAIL pend_older_mis got %0d exp 1", b2_mispredict); end
      nvec++; if (b2_rob_idx !== 7'd20) begin nerr++; $display("FAIL pend_older_rob got %0d exp 20", b2_rob_idx); end
   endtask

   task automatic test_mask_kill();
      do_reset();
      set_port(0, 1, 1, 0, '0, 0, 30);
      set_port(1, 1, 1, 0, 20'h1, 4, 10);
      #1;
      nvec++; if (b1_mispredict_mask !== 20'h11) begin nerr++; $display("FAIL kill_b1_mis got %h exp 11", b1_mispredict_mask); end
      tick();
      clear_inputs();
      nvec++; if (b2_rob_idx !== 7'd30) begin nerr++; $display("FAIL kill_b2_rob got %0d exp 30", b2_rob_idx); end
      nvec++; if (b2_br_tag !== 5'd0) begin nerr++; $display("FAIL kill_b2_tag got %0d exp 0", b2_br_tag); end
      nvec++; if (b2_mispredict !== 1'b1) begin nerr++; $display("FAIL kill_b2_mis got %0d exp 1", b2_mispredict); end
   endtask

   task automatic test_ack_accept();
      do_reset();
      redirect_ack = 1'b1;
      tick();
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL ack_idle got %0d exp 0", redirect_pending); end
      redirect_ack = 1'b0;
      set_port(0, 1, 1, 0, '0, 1, 40);
      tick();
      redirect_ack = 1'b1;
      set_port(0, 1, 1, 0, '0, 2, 20);
      tick();
      nvec++; if (redirect_pending !== 1'b1) begin nerr++; $display("FAIL ackacc_pending got %0d exp 1", redirect_pending); end
      nvec++; if (b2_mispredict !== 1'b1) begin nerr++; $display("FAIL ackacc_mis got %0d exp 1", b2_mispredict); end
      nvec++; if (b2_rob_idx !== 7'd20) begin nerr++; $display("FAIL ackacc_rob got %0d exp 20", b2_rob_idx); end
      clear_inputs();
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL ack_alone got %0d exp 0", redirect_pending); end
      nvec++; if (b2_mispredict !== 1'b0) begin nerr++; $display("FAIL ack_alone_mis got %0d exp 0", b2_mispredict); end
   endtask

   task automatic test_flush_reset();
      do_reset();
      flush = 1'b1;
      set_port(0, 1, 1, 0, '0, 1, 10);
      tick();
      nvec++; if (b2_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid got %0d exp 0", b2_valid); end
      nvec++; if (b2_mispredict !== 1'b0) begin nerr++; $display("FAIL flush_mis got %0d exp 0", b2_mispredict); end
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL flush_pending got %0d exp 0", redirect_pending); end
      flush = 1'b0;
      tick();
      clear_inputs();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL flush_in_pend got %0d exp 0", redirect_pending); end
      set_port(0, 1, 1, 0, '0, 1, 10);
      tick();
      nvec++; if (redirect_pending !== 1'b1) begin nerr++; $display("FAIL pre_reset_pend got %0d exp 1", redirect_pending); end
      reset = 1'b1;
      set_port(1, 1, 1, 0, '0, 2, 5);
      tick();
      reset = 1'b0;
      clear_inputs();
      nvec++; if (b2_valid !== 1'b0) begin nerr++; $display("FAIL rst_pend_valid got %0d exp 0", b2_valid); end
      nvec++; if (b2_mispredict !== 1'b0) begin nerr++; $display("FAIL rst_pend_mis got %0d exp 0", b2_mispredict); end
      nvec++; if (redirect_pending !== 1'b0) begin nerr++; $display("FAIL rst_pend_pending got %0d exp 0", redirect_pending); end
      nvec++; if (b2_rob_idx !== 7'd0) begin nerr++; $display("FAIL rst_pend_rob got %0d exp 0", b2_rob_idx); end
   endtask

   function automatic int age(input int rob, input int head);
      return (rob - head + 128) % 128;
   endfunction

   // Random traffic against a rule-level model of the redirect protocol
   task automatic test_random();
      int v[2], m[2], tk[2], tag[2], rob[2], ftq[2], toff[2];
      logic [19:0] msk[2];
      int head, sel, old;
      bit acc, fl, ack, m_pend, e_valid, e_mis;
      int m_prob, e_rob, e_tag, e_ftq, e_toff, e_tk;
      logic [19:0] e_res, e_misk;
      do_reset();
      m_pend = 0; m_prob = 0;
      e_rob = 0; e_tag = 0; e_ftq = 0; e_toff = 0; e_tk = 0;
      for (int n = 0; n < 400; n++) begin
         clear_inputs();
         head = $urandom_range(0, 127);
         fl = ($urandom_range(0, 19) == 0);
         ack = ($urandom_range(0, 4) == 0);
         for (int p = 0; p < 2; p++) begin
            v[p] = ($urandom_range(0, 9) < 7) ? 1 : 0;
            m[p] = $urandom_range(0, 1);
            tk[p] = $urandom_range(0, 1);
            tag[p] = $urandom_range(0, 19);
            rob[p] = $urandom_range(0, 127);
            ftq[p] = $urandom_range(0, 63);
            toff[p] = $urandom_range(0, 2097151);
            msk[p] = '0;
            if ($urandom_range(0, 2) == 0) msk[p][$urandom_range(0, 19)] = 1'b1;
            set_port(p, v[p][0], m[p][0], tk[p][0], msk[p], tag[p], rob[p]);
            set_payload(p, ftq[p], 0, 0, 0, 0, 0, toff[p]);
         end
         rob_head_idx = 7'(head);
         flush = fl;
         redirect_ack = ack;
         e_res = '0; e_misk = '0;
         for (int p = 0; p < 2; p++) begin
            if (v[p] != 0) e_res[tag[p]] = 1'b1;
            if (v[p] != 0 && m[p] != 0) e_misk[tag[p]] = 1'b1;
         end
         sel = -1; old = -1;
         for (int p = 0; p < 2; p++) begin
            if (v[p] != 0 && (old < 0 || age(rob[p], head) < age(rob[old], head))) old = p;
            if (v[p] != 0 && m[p] != 0 && (msk[p] & e_misk) == 0 &&
                (sel < 0 || age(rob[p], head) < age(rob[sel], head))) sel = p;
         end
         acc = (sel >= 0) && (!m_pend || age(rob[sel], head) < age(m_prob, head));
         e_valid = (v[0] != 0 || v[1] != 0) && !fl;
         e_mis = acc && !fl;
         if (acc) begin
            e_rob = rob[sel]; e_tag = tag[sel]; e_ftq = ftq[sel]; e_toff = toff[sel]; e_tk = tk[sel];
         end else if (old >= 0) begin
            e_rob = rob[old]; e_tag = tag[old]; e_ftq = ftq[old]; e_toff = toff[old]; e_tk = tk[old];
         end
         if (fl) m_pend = 0;
         else if (acc) begin m_pend = 1; m_prob = rob[sel]; end
         else if (m_pend && ack) m_pend = 0;
         #1;
         nvec++; if (b1_resolve_mask !== e_res) begin nerr++; $display("FAIL rnd%0d_b1_res got %h exp %h", n, b1_resolve_mask, e_res); end
         nvec++; if (b1_mispredict_mask !== e_misk) begin nerr++; $display("FAIL rnd%0d_b1_mis got %h exp %h", n, b1_mispredict_mask, e_misk); end
         tick();
         nvec++; if (b2_valid !== e_valid) begin nerr++; $display("FAIL rnd%0d_valid got %0d exp %0d", n, b2_valid, e_valid); end
         nvec++; if (b2_mispredict !== e_mis) begin nerr++; $display("FAIL rnd%0d_mis got %0d exp %0d", n, b2_mispredict, e_mis); end
         nvec++; if (redirect_pending !== m_pend) begin nerr++; $display("FAIL rnd%0d_pending got %0d exp %0d", n, redirect_pending, m_pend); end
         nvec++; if (b2_rob_idx !== 7'(e_rob) || b2_br_tag !== 5'(e_tag) || b2_ftq_idx !== 6'(e_ftq) ||
                     b2_target_offset !== 21'(e_toff) || b2_taken !== 1'(e_tk)) begin
            nerr++;
            $display("FAIL rnd%0d_payload got rob=%0d tag=%0d ftq=%0d toff=%0d tk=%0d exp rob=%0d tag=%0d ftq=%0d toff=%0d tk=%0d",
                     n, b2_rob_idx, b2_br_tag, b2_ftq_idx, b2_target_offset, b2_taken, e_rob, e_tag, e_ftq, e_toff, e_tk);
         end
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_age_wrap();
      test_pending_older();
      test_mask_kill();
      test_ack_accept();
      test_flush_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
